binterweave_seq: RTL

- Sequential, parametrised backward-pass engine for the ternary-shift interweave layer.
- Computes input gradient dx and weight gradient dw from operands x, w, forward output y and output gradient dy.
- Processes LANES positions per clock over X_SIZE/LANES beats, with valid/ready handshakes on both sides.
- Generalises the shift to any trit index below NUM_TRITS (shift wraps modulo X_SIZE); out-of-range trits are flagged.

---
 rtl/binterweave_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/binterweave_seq.sv
// binterweave_seq: multi-beat backward pass for the ternary-shift interweave layer.
// It captures one operand bundle, then computes LANES positions of dx/dw per clock
// over X_SIZE/LANES beats, and presents the result under a valid/ready handshake.
module binterweave_seq #(
  parameter int X_SIZE    = 1024,
  parameter int W_SIZE    = 3 * X_SIZE,
  parameter int TRIT_SIZE = 4,
  parameter int NUM_TRITS = 7,
  parameter int LANES     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_SIZE-1:0]    x,
  input  logic [W_SIZE-1:0]    w,
  input  logic [X_SIZE-1:0]    y,
  input  logic [X_SIZE-1:0]    dy,
  input  logic [TRIT_SIZE-1:0] trit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_SIZE-1:0]    dx,
  output logic [W_SIZE-1:0]    dw,
  output logic                 trit_err
);

  localparam int NB   = X_SIZE / LANES;
  localparam int AW   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int IW   = AW + 1;
  localparam int WAW  = $clog2(W_SIZE);
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int NTAB = 2 ** TRIT_SIZE;

  if (W_SIZE != 3 * X_SIZE) begin : g_chk_w
    $error("binterweave_seq: W_SIZE must equal 3*X_SIZE");
  end
  if (X_SIZE % LANES != 0) begin : g_chk_lanes
    $error("binterweave_seq: X_SIZE must be a multiple of LANES");
  end
  if (NUM_TRITS > NTAB) begin : g_chk_trits
    $error("binterweave_seq: NUM_TRITS exceeds 2**TRIT_SIZE");
  end

  // (3**t) mod N, reduced step by step so it never overflows for large t.
  function automatic int pow3_mod(input int t);
    int s;
    s = 1 % X_SIZE;
    for (int k = 0; k < t; k++) s = (s * 3) % X_SIZE;
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [X_SIZE-1:0]   x_reg;
  logic [W_SIZE-1:0]   w_reg;
  logic [X_SIZE-1:0]   d_reg;
  logic [AW-1:0]       shift_reg;
  logic                err_reg;
  logic [BW-1:0]       beat_reg;
  logic [X_SIZE-1:0]   dx_reg;
  logic [W_SIZE-1:0]   dw_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;

  logic [AW-1:0]       shift_tab [NTAB];
  logic [LANES-1:0]    lane_dx;
  logic [3*LANES-1:0]  lane_dw;
  logic [AW-1:0]       dx_base;
  logic [WAW-1:0]      dw_base;

  // Shift table; illegal trit slots read as zero (their beats are zeroed anyway).
  for (genvar gi = 0; gi < NTAB; gi++) begin : g_tab
    if (gi < NUM_TRITS) begin : g_legal
      assign shift_tab[gi] = AW'(pow3_mod(gi));
    end else begin : g_illegal
      assign shift_tab[gi] = '0;
    end
  end

  assign dx_base = AW'(beat_reg * LANES);
  assign dw_base = WAW'(3 * dx_base);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IW-1:0]  i_full;
    logic [IW-1:0]  p_sum;
    logic [AW-1:0]  i_idx, p_idx, m_idx;
    logic [WAW-1:0] wi0, wi1, wi2, wp2, wm1;
    logic           a_bit, b_bit, c_bit;
    logic           ldx;
    logic [2:0]     ldw;

    // Position index, its +S / -S neighbours (mod N), and the lane's gradient bits.
    always_comb begin
      i_full = IW'(beat_reg) * IW'(LANES) + IW'(gi);
      p_sum  = i_full + IW'(shift_reg);
      i_idx  = AW'(i_full);
      p_idx  = AW'((p_sum >= IW'(X_SIZE)) ? (p_sum - IW'(X_SIZE)) : p_sum);
      m_idx  = AW'((i_full >= IW'(shift_reg)) ? (i_full - IW'(shift_reg))
                                              : (i_full + IW'(X_SIZE) - IW'(shift_reg)));
      wi0    = WAW'(3 * i_idx);
      wi1    = WAW'(3 * i_idx + 1);
      wi2    = WAW'(3 * i_idx + 2);
      wp2    = WAW'(3 * p_idx + 2);
      wm1    = WAW'(3 * m_idx + 1);
      a_bit  = x_reg[i_idx] ^ d_reg[p_idx] ^ w_reg[wp2];
      b_bit  = x_reg[i_idx] ^ d_reg[m_idx] ^ w_reg[wm1];
      c_bit  = x_reg[i_idx] ^ d_reg[i_idx] ^ w_reg[wi0];
      ldx    = 1'b0;
      ldw    = 3'b000;
      if (!err_reg) begin
        ldx    = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
        ldw[2] = x_reg[m_idx] ^ d_reg[i_idx] ^ w_reg[wi2];
        ldw[1] = x_reg[p_idx] ^ d_reg[i_idx] ^ w_reg[wi1];
        ldw[0] = c_bit;
      end
    end

    assign lane_dx[gi]          = ldx;
    assign lane_dw[3*gi +: 3]   = ldw;
  end

  // Control FSM: capture in IDLE, one beat per clock in RUN, hold result in DONE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      x_reg         <= '0;
      w_reg         <= '0;
      d_reg         <= '0;
      shift_reg     <= '0;
      err_reg       <= 1'b0;
      beat_reg      <= '0;
      dx_reg        <= '0;
      dw_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg        <= x;
            w_reg        <= w;
            d_reg        <= y ^ dy;
            shift_reg    <= shift_tab[trit];
            err_reg      <= ({1'b0, trit} >= (TRIT_SIZE+1)'(NUM_TRITS));
            beat_reg     <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          dx_reg[dx_base +: LANES]   <= lane_dx;
          dw_reg[dw_base +: 3*LANES] <= lane_dw;
          if (beat_reg == BW'(NB - 1)) begin
            beat_reg      <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            beat_reg <= beat_reg + BW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign dx        = dx_reg;
  assign dw        = dw_reg;
  assign trit_err  = err_reg;

endmodule
